// File: rtl/riscv_div_pkg.sv
// -----------------------------------------------------------------------------
// riscv_div_pkg
//
// Purpose: shared types and constants for the RV32M divide/remainder
//          sequencer and the EX-stage ALU it borrows.
//
// Contents:
//   div_op_e      operation encoding, matches funct3[1:0] of DIV/DIVU/REM/REMU
//   div_state_e   sequencer states
//   ALU_*         ALU opcode constants
//   DIV_ITERS     number of restoring-division iterations (one per bit)
//   is_signed_op  true for DIV and REM
//   is_rem_op     true for REM and REMU
// -----------------------------------------------------------------------------
package riscv_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ITER  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } div_state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SGE  = 4'b1100;
    localparam logic [3:0] ALU_SGEU = 4'b1101;

    localparam int DIV_ITERS = 32;

    // Bit 0 of the op is the "unsigned" flag in the funct3 encoding.
    function automatic logic is_signed_op(input div_op_e op);
        return ~op[0];
    endfunction

    // Bit 1 of the op selects remainder over quotient.
    function automatic logic is_rem_op(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_sequencer_alu.sv
// -----------------------------------------------------------------------------
// alu
//
// Purpose: the EX-stage integer ALU, purely combinational. The divide
//          sequencer instantiates copies of it for subtract and compare.
//
// Ports:
//   alu_op  in   4      opcode (see ALU_* in riscv_div_pkg)
//   a       in   WIDTH  first operand
//   b       in   WIDTH  second operand
//   y       out  WIDTH  result; compares return 0 or 1 in bit 0
// -----------------------------------------------------------------------------
module alu
    import riscv_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-2:0] PAD = '0;

    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_SLT:  y = {PAD, ($signed(a) <  $signed(b))};
            ALU_SLTU: y = {PAD, (a <  b)};
            ALU_SGE:  y = {PAD, ($signed(a) >= $signed(b))};
            ALU_SGEU: y = {PAD, (a >= b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Purpose: multi-cycle RV32M DIV/DIVU/REM/REMU controller for the EX stage.
//          Runs a radix-2 restoring division, one quotient bit per cycle,
//          using two copies of the shared ALU (subtract and unsigned >=).
//          Divide-by-zero and signed overflow bypass the iterations.
//
// Optional feature: define DIV_EARLY_OUT_EN to add a third ALU compare at
//          acceptance; when |dividend| < |divisor| the iterations are skipped.
//
// Ports:
//   clk       in   1     rising-edge clock
//   rst_n     in   1     asynchronous active-low reset
//   start     in   1     request, sampled only while ready
//   op        in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   XLEN  rs1
//   divisor   in   XLEN  rs2
//   flush     in   1     pipeline kill, aborts any operation in flight
//   ready     out  1     a start is accepted this cycle
//   busy      out  1     operation in flight (stall request)
//   done      out  1     one-cycle pulse, result valid
//   result    out  XLEN  quotient or remainder, held until overwritten
// -----------------------------------------------------------------------------
module div_sequencer
    import riscv_div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DIV_ITERS - 1);

    div_state_e      state;
    div_state_e      next_state;

    div_op_e         op_q;
    logic            sign_q;
    logic            sign_r;
    logic [XLEN-1:0] dvs_abs;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CNTW-1:0] count;
    logic [XLEN-1:0] result_q;

    div_op_e         op_in;
    logic            signed_in;
    logic            accept;
    logic            div_by_zero;
    logic            overflow;
    logic            early_out;
    logic            special;
    logic [XLEN-1:0] abs_dvd;
    logic [XLEN-1:0] abs_dvs;

    logic [XLEN-1:0] shifted;
    logic            msb;
    logic            qbit;
    logic            neg_q;
    logic            neg_r;

    logic [3:0]      alu_a_op;
    logic [XLEN-1:0] alu_a_a;
    logic [XLEN-1:0] alu_a_b;
    logic [XLEN-1:0] alu_a_y;
    logic [3:0]      alu_b_op;
    logic [XLEN-1:0] alu_b_a;
    logic [XLEN-1:0] alu_b_b;
    logic [XLEN-1:0] alu_b_y;

    assign op_in     = div_op_e'(op);
    assign signed_in = is_signed_op(op_in);
    assign accept    = start & ready & ~flush;

    // Partial remainder shifted left with the next dividend bit; msb is the
    // bit that falls off the 32-bit register and acts as a 33rd bit.
    assign shifted = {rem[XLEN-2:0], quo[XLEN-1]};
    assign msb     = rem[XLEN-1];
    assign qbit    = msb | alu_b_y[0];

    assign neg_q = sign_q & is_signed_op(op_q);
    assign neg_r = sign_r & is_signed_op(op_q);

    // The two ALUs are time-shared: in the accept cycle they negate the
    // operands, during ITER they subtract/compare, and in FIXUP they negate
    // the quotient and remainder.
    always_comb begin
        alu_a_op = ALU_SUB;
        alu_a_a  = '0;
        alu_a_b  = dividend;
        alu_b_op = ALU_SUB;
        alu_b_a  = '0;
        alu_b_b  = divisor;
        case (state)
            ITER: begin
                alu_a_op = ALU_SUB;
                alu_a_a  = shifted;
                alu_a_b  = dvs_abs;
                alu_b_op = ALU_SGEU;
                alu_b_a  = shifted;
                alu_b_b  = dvs_abs;
            end
            FIXUP: begin
                alu_a_op = ALU_SUB;
                alu_a_a  = '0;
                alu_a_b  = quo;
                alu_b_op = ALU_SUB;
                alu_b_a  = '0;
                alu_b_b  = rem;
            end
            default: begin
                alu_a_op = ALU_SUB;
                alu_a_a  = '0;
                alu_a_b  = dividend;
                alu_b_op = ALU_SUB;
                alu_b_a  = '0;
                alu_b_b  = divisor;
            end
        endcase
    end

    alu #(.WIDTH(XLEN)) u_alu_a (
        .alu_op (alu_a_op),
        .a      (alu_a_a),
        .b      (alu_a_b),
        .y      (alu_a_y)
    );

    alu #(.WIDTH(XLEN)) u_alu_b (
        .alu_op (alu_b_op),
        .a      (alu_b_a),
        .b      (alu_b_b),
        .y      (alu_b_y)
    );

    // Absolute operand values; only meaningful in IDLE/DONE, which are the
    // only states where a start can be accepted.
    assign abs_dvd = (signed_in & dividend[XLEN-1]) ? alu_a_y : dividend;
    assign abs_dvs = (signed_in & divisor[XLEN-1])  ? alu_b_y : divisor;

    assign div_by_zero = (divisor == '0);
    assign overflow    = signed_in & (dividend == MOST_NEG) & (divisor == ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
    logic [XLEN-1:0] alu_c_y;

    alu #(.WIDTH(XLEN)) u_alu_c (
        .alu_op (ALU_SLTU),
        .a      (abs_dvd),
        .b      (abs_dvs),
        .y      (alu_c_y)
    );

    assign early_out = ~div_by_zero & (|alu_c_y);
`else
    assign early_out = 1'b0;
`endif

    assign special = div_by_zero | overflow | early_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides everything, including a start.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        next_state = special ? FIXUP : ITER;
                    end
                end
                ITER: begin
                    if (count == LAST_CNT) begin
                        next_state = FIXUP;
                    end
                end
                FIXUP: begin
                    next_state = DONE;
                end
                DONE: begin
                    if (accept) begin
                        next_state = special ? FIXUP : ITER;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy  = (state == ITER) || (state == FIXUP);
        ready = (state == IDLE) || (state == DONE);
        done  = (state == DONE);
    end

    // Datapath registers. Divide-by-zero forces the quotient sign to positive
    // so the all-ones quotient survives FIXUP; the remainder keeps the
    // dividend sign so it comes back as the raw dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= DIV;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dvs_abs  <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            sign_q  <= signed_in & (dividend[XLEN-1] ^ divisor[XLEN-1]) & ~div_by_zero;
            sign_r  <= signed_in & dividend[XLEN-1];
            dvs_abs <= abs_dvs;
            count   <= '0;
            if (div_by_zero) begin
                quo <= ALL_ONES;
                rem <= abs_dvd;
            end else if (overflow) begin
                quo <= abs_dvd;
                rem <= '0;
            end else if (early_out) begin
                quo <= '0;
                rem <= abs_dvd;
            end else begin
                quo <= abs_dvd;
                rem <= '0;
            end
        end else if (!flush && state == ITER) begin
            rem   <= qbit ? alu_a_y : shifted;
            quo   <= {quo[XLEN-2:0], qbit};
            count <= count + 1'b1;
        end else if (!flush && state == FIXUP) begin
            if (is_rem_op(op_q)) begin
                result_q <= neg_r ? alu_b_y : rem;
            end else begin
                result_q <= neg_q ? alu_a_y : quo;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
//
// Purpose: directed self-checking bench for div_sequencer. Checks reset
//          values, cycle-exact latency of normal and special paths, signed
//          fixups, flush, asynchronous reset mid-operation and back-to-back
//          starts. Define DIV_EARLY_OUT_EN to match an early-out build.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int passed = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = 34;
`endif

    div_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
    endtask

    // Start one op, then check busy/done on every cycle up to the expected
    // done cycle, the result there, and the return to idle afterwards.
    task automatic runOp(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input int latency, input logic [31:0] expected);
        int bad_busy;
        int bad_done;
        bad_busy = 0;
        bad_done = 0;
        applyStimulus(o, a, b);
        tick;
        start = 1'b0;
        for (int c = 1; c < latency; c++) begin
            if (done !== 1'b0) bad_done++;
            if (busy !== 1'b1) bad_busy++;
            tick;
        end
        checkOutput({tag, " early done cycles"}, 32'(bad_done), 32'd0);
        checkOutput({tag, " missing busy cycles"}, 32'(bad_busy), 32'd0);
        checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, " result"}, result, expected);
        tick;
        checkOutput({tag, " done after"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " ready after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int seen_done;

        // Reset values, asserted asynchronously between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset ready", {31'd0, ready}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // Normal path, unsigned and signed.
        runOp("DIVU 100/7", 2'b01, 32'd100, 32'd7, 34, 32'd14);
        runOp("REMU 100/7", 2'b11, 32'd100, 32'd7, 34, 32'd2);
        runOp("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
        runOp("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
        runOp("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 34, 32'd1);
        runOp("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD);

        // Divide by zero and signed overflow.
        runOp("DIVU 5/0", 2'b01, 32'd5, 32'd0, 2, 32'hFFFF_FFFF);
        runOp("REM -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB);
        runOp("DIV -5/0", 2'b00, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFF);
        runOp("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000);
        runOp("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0);

        // Dividend smaller than divisor (early-out candidate).
        runOp("DIVU 3/10", 2'b01, 32'd3, 32'd10, SMALL_LAT, 32'd0);
        runOp("REMU 3/10", 2'b11, 32'd3, 32'd10, SMALL_LAT, 32'd3);

        // Flush at cycle 10: idle at cycle 11, no done, result keeps 3.
        applyStimulus(2'b01, 32'd1000, 32'd3);
        tick;
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checkOutput("flush ready", {31'd0, ready}, 32'd1);
        checkOutput("flush busy", {31'd0, busy}, 32'd0);
        checkOutput("flush done", {31'd0, done}, 32'd0);
        checkOutput("flush result", result, 32'd3);
        seen_done = 0;
        for (int c = 0; c < 30; c++) begin
            if (done !== 1'b0) seen_done++;
            tick;
        end
        checkOutput("flush no done", 32'(seen_done), 32'd0);

        // Flush together with start: start is dropped.
        applyStimulus(2'b01, 32'd1000, 32'd3);
        flush = 1'b1;
        tick;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush+start busy", {31'd0, busy}, 32'd0);
        checkOutput("flush+start ready", {31'd0, ready}, 32'd1);
        tick;

        // Asynchronous reset at cycle 20 of an operation.
        applyStimulus(2'b01, 32'd1000, 32'd3);
        tick;
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset ready", {31'd0, ready}, 32'd1);
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset done", {31'd0, done}, 32'd0);
        checkOutput("midreset result", result, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        runOp("DIVU 9/3", 2'b01, 32'd9, 32'd3, 34, 32'd3);

        // Back-to-back: start held high through the first done cycle.
        begin
            int bad_busy;
            int bad_done;
            bad_busy = 0;
            bad_done = 0;
            applyStimulus(2'b01, 32'd15, 32'd4);
            tick;
            for (int c = 1; c < 34; c++) begin
                if (done !== 1'b0) bad_done++;
                if (busy !== 1'b1) bad_busy++;
                tick;
            end
            checkOutput("b2b first done", {31'd0, done}, 32'd1);
            checkOutput("b2b first result", result, 32'd3);
            checkOutput("b2b first ready", {31'd0, ready}, 32'd1);
            tick;
            checkOutput("b2b second accepted", {31'd0, busy}, 32'd1);
            for (int c = 35; c < 68; c++) begin
                if (done !== 1'b0) bad_done++;
                if (busy !== 1'b1) bad_busy++;
                tick;
            end
            checkOutput("b2b early done cycles", 32'(bad_done), 32'd0);
            checkOutput("b2b missing busy cycles", 32'(bad_busy), 32'd0);
            checkOutput("b2b second done", {31'd0, done}, 32'd1);
            checkOutput("b2b second result", result, 32'd3);
            start = 1'b0;
            tick;
            checkOutput("b2b idle done", {31'd0, done}, 32'd0);
            checkOutput("b2b idle busy", {31'd0, busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle RV32M divide/remainder controller in the EX stage. Handles DIV, DIVU, REM and REMU.
- Sequences two instances of the shared 32-bit ALU through a radix-2 restoring division, one quotient bit per cycle.
- Accepts one operation at a time with a start/ready handshake. Produces a registered result with a one-cycle done pulse.
- The hazard unit stalls the pipeline on busy.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNTW, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- flush  input  1  pipeline kill; aborts the operation in flight.
- ready  output  1  can accept start this cycle.
- busy  output  1  operation in flight; stall request.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, result=0, all internal registers 0.
- States: IDLE, ITER, FIXUP, DONE.
  - busy = state in {ITER, FIXUP}.
  - ready = state in {IDLE, DONE}.
  - done = (state==DONE).
- Acceptance, in cycle 0 when start&ready&!flush:
  - Latch op.
  - Latch signs (signed ops only): sign_q = dvd[31]^dvs[31]; sign_r = dvd[31].
  - Latch absolute values: negate via ALU SUB from 0 for signed ops with a negative operand.
  - Clear rem, set quo=|dividend|, count=0.
- Special cases at acceptance go directly to FIXUP (cycle 1), then DONE (cycle 2):
  - divisor==0: quotient=32'hFFFF_FFFF, remainder=dividend.
  - Signed DIV/REM with dividend=32'h8000_0000 and divisor=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
- Normal path runs ITER for cycles 1..32. Each cycle:
  - {msb, shifted} = {rem, quo[31]}.
  - ALU-A performs SUB: shifted − |divisor|.
  - ALU-B performs SGEU: shifted ≥ |divisor|.
  - qbit = msb | sgeu.
  - rem ← qbit ? difference : shifted.
  - quo ← {quo[30:0], qbit}.
  - count++. Leave ITER when count==31.
- FIXUP (cycle 33):
  - Quotient is negated when sign_q and a signed op.
  - Remainder is negated when sign_r and a signed op.
  - result register ← quotient for DIV/DIVU, remainder for REM/REMU.
- DONE (cycle 34): done=1 for exactly one cycle.
  - A start in this cycle is accepted (back-to-back), giving ITER from the next cycle.
  - Otherwise go to IDLE.
- Latency, counted from the accept cycle (cycle 0):
  - done in cycle 34 on the normal path.
  - done in cycle 2 on a special case.
- start while ready=0 is ignored with no queuing; the requester holds start.
- flush in any state: next state IDLE, done stays 0, result unchanged.
- flush with start in the same cycle: flush wins, start not accepted.
- rst_n deasserted mid-operation: immediate IDLE; no done pulse.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - At acceptance, a third ALU compare (SLTU) is evaluated: |dividend| < |divisor| with divisor≠0.
  - If true, go straight to FIXUP with quotient=0 and remainder=|dividend|, signs applied normally; done in cycle 2.
- Undefined: no extra compare; all non-special operations take 34 cycles.

Decomposition:
- Package riscv_div_pkg holds:
  - div_op_e (DIV, DIVU, REM, REMU).
  - div_state_e (IDLE, ITER, FIXUP, DONE).
  - ALU opcode constants ALU_SUB=4'b0001, ALU_SLTU=4'b1001, ALU_SGEU=4'b1101.
  - DIV_ITERS=32.
- Sub-modules: only the existing alu, instantiated twice (three times with DIV_EARLY_OUT_EN). No new sub-module is introduced.

Test Plan:
- DIVU 100/7, start at cycle 0 -> busy cycles 1–33, done only at cycle 34, result=14; REMU same operands -> 2.
- DIV -7/2 -> 32'hFFFF_FFFD (-3); REM -7/2 -> 32'hFFFF_FFFF (-1); REM 7/-2 -> 1.
- Divide by zero:
  - DIVU 5/0 -> 32'hFFFF_FFFF.
  - REM -5/0 -> 32'hFFFF_FFFB.
  - done at cycle 2.
- Overflow: DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000; REM -> 0; done at cycle 2.
- Flush and reset:
  - flush at cycle 10 -> IDLE at cycle 11, ready=1, no done, result unchanged.
  - rst_n pulsed low at cycle 20 -> outputs return to reset values asynchronously.
  - A new DIVU 9/3 afterwards -> 3.
- Back-to-back: start DIVU 15/4 held high -> first done cycle 34 (result 3), second op accepted in cycle 34, second done cycle 68; with DIV_EARLY_OUT_EN, DIVU 3/10 -> result 0, done cycle 2.
